// File: rtl/rv32_regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register pending-write scoreboard for decode hazard detection.
module rv32_regfile_mp #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            i_we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]      i_wr_data,
  input  logic [NUM_WR-1:0]            i_wr_clr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_RD*WIDTH-1:0]      o_rd_data,
  output logic [NUM_RD-1:0]            o_rd_busy,
  input  logic                         i_alloc,
  input  logic [ADDR_WIDTH-1:0]        i_alloc_addr,
  input  logic                         i_flush,
  output logic [ADDR_WIDTH:0]          o_pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]      regs_reg [DEPTH];
  logic [DEPTH-1:0]      pend_reg;
  logic [DEPTH-1:0]      pend_next;
  logic [ADDR_WIDTH:0]   cnt_reg;

  function automatic logic [ADDR_WIDTH:0] popcnt(input logic [DEPTH-1:0] v);
    logic [ADDR_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (ADDR_WIDTH + 1)'(v[i]);
    return c;
  endfunction

  // Ports are visited in ascending order so the highest index wins a conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_we[k] && i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)
          regs_reg[i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= i_wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Clear first, then alloc, so a same-cycle alloc on a retiring register keeps it pending.
  always_comb begin
    pend_next = pend_reg;
    for (int k = 0; k < NUM_WR; k++) begin
      if (i_we[k] && i_wr_clr[k] && i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)
        pend_next[i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (i_alloc && i_alloc_addr != '0)
      pend_next[i_alloc_addr] = 1'b1;
    if (i_flush)
      pend_next = '0;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= popcnt(pend_next);
    end
  end

  assign o_pend_cnt = cnt_reg;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] rd_addr;
      logic [WIDTH-1:0]      rd_val;
      logic                  rd_busy;

      assign rd_addr = i_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
        rd_val  = regs_reg[rd_addr];
        rd_busy = pend_reg[rd_addr];
        if (BYPASS != 0) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (i_we[k] && i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr) begin
              rd_val = i_wr_data[k*WIDTH +: WIDTH];
              if (i_wr_clr[k]) rd_busy = 1'b0;
            end
          end
        end
        if (rd_addr == '0 || rst) begin
          rd_val  = '0;
          rd_busy = 1'b0;
        end
      end

      assign o_rd_data[gi*WIDTH +: WIDTH] = rd_val;
      assign o_rd_busy[gi]                = rd_busy;
    end
  endgenerate

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// Directed bench for rv32_regfile_mp: one bypassing and one non-bypassing
// instance share all inputs; expected values are hand-computed constants.
module tb_rv32_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_we;
  logic [9:0]  i_wr_addr;
  logic [63:0] i_wr_data;
  logic [1:0]  i_wr_clr;
  logic [9:0]  i_rd_addr;
  logic        i_alloc;
  logic [4:0]  i_alloc_addr;
  logic        i_flush;

  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic [5:0]  pend_cnt, nb_pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_wr_clr(i_wr_clr), .i_rd_addr(i_rd_addr), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
    .i_alloc(i_alloc), .i_alloc_addr(i_alloc_addr), .i_flush(i_flush), .o_pend_cnt(pend_cnt)
  );

  rv32_regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_wr_clr(i_wr_clr), .i_rd_addr(i_rd_addr), .o_rd_data(nb_rd_data), .o_rd_busy(nb_rd_busy),
    .i_alloc(i_alloc), .i_alloc_addr(i_alloc_addr), .i_flush(i_flush), .o_pend_cnt(nb_pend_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_we = '0; i_wr_clr = '0; i_alloc = 1'b0; i_alloc_addr = '0; i_flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic c);
    i_we[p]               = 1'b1;
    i_wr_clr[p]           = c;
    i_wr_addr[p*5 +: 5]   = a;
    i_wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    i_rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_wr_addr = '0; i_wr_data = '0; i_rd_addr = '0;
    idle();
    tick(); tick();
    check("cnt_in_reset", 32'(pend_cnt), 32'd0);
    rst = 1'b0;

    // Reset state of every register on both read ports
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check($sformatf("rst_data_x%0d", i), rd_data[31:0], 32'd0);
      check($sformatf("rst_busy_x%0d", i), 32'(rd_busy), 32'd0);
    end
    check("rst_cnt", 32'(pend_cnt), 32'd0);

    // Reset asserted in the middle of a write cycle
    wr(0, 5'd10, 32'h0000_0055, 1'b0);
    rd(5'd10, 5'd10);
    check("byp_before_rst", rd_data[31:0], 32'h0000_0055);
    #2 rst = 1'b1;
    #1;
    check("read_during_rst", rd_data[31:0], 32'd0);
    tick();
    rst = 1'b0;
    idle();
    rd(5'd10, 5'd0);
    check("midwrite_rst_lost", rd_data[31:0], 32'd0);

    // Basic write / read, x0 hardwired
    wr(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
    tick(); idle();
    rd(5'd5, 5'd0);
    check("wr_x5", rd_data[31:0], 32'hDEAD_BEEF);
    wr(0, 5'd0, 32'h0000_1234, 1'b0);
    rd(5'd0, 5'd0);
    check("x0_byp_zero", rd_data[31:0], 32'd0);
    tick(); idle();
    rd(5'd0, 5'd5);
    check("x0_zero", rd_data[31:0], 32'd0);
    check("x5_port1", rd_data[63:32], 32'hDEAD_BEEF);

    // Bypass vs no bypass in the write cycle
    wr(1, 5'd7, 32'hA5A5_A5A5, 1'b0);
    rd(5'd0, 5'd7);
    check("byp1_same_cycle", rd_data[63:32], 32'hA5A5_A5A5);
    check("byp0_same_cycle", nb_rd_data[63:32], 32'd0);
    tick(); idle();
    rd(5'd0, 5'd7);
    check("byp0_after", nb_rd_data[63:32], 32'hA5A5_A5A5);

    // Same-address conflict: port1 wins
    wr(0, 5'd9, 32'h11, 1'b0);
    wr(1, 5'd9, 32'h22, 1'b0);
    rd(5'd9, 5'd0);
    check("conflict_byp", rd_data[31:0], 32'h22);
    tick(); idle();
    rd(5'd9, 5'd9);
    check("conflict_x9", rd_data[31:0], 32'h22);
    check("conflict_x9_nb", nb_rd_data[63:32], 32'h22);

    // Scoreboard alloc / clear
    i_alloc = 1'b1; i_alloc_addr = 5'd3;
    tick(); idle();
    rd(5'd3, 5'd0);
    check("alloc_busy", 32'(rd_busy[0]), 32'd1);
    check("alloc_cnt", 32'(pend_cnt), 32'd1);
    i_alloc = 1'b1; i_alloc_addr = 5'd3;
    tick(); idle();
    check("realloc_cnt", 32'(pend_cnt), 32'd1);
    i_alloc = 1'b1; i_alloc_addr = 5'd0;
    tick(); idle();
    check("alloc_x0_cnt", 32'(pend_cnt), 32'd1);
    wr(1, 5'd3, 32'h33, 1'b1);
    rd(5'd3, 5'd0);
    check("clr_busy_byp", 32'(rd_busy[0]), 32'd0);
    check("clr_busy_nb", 32'(nb_rd_busy[0]), 32'd1);
    tick(); idle();
    rd(5'd3, 5'd0);
    check("clr_busy", 32'(rd_busy[0]), 32'd0);
    check("clr_cnt", 32'(pend_cnt), 32'd0);
    check("clr_data", rd_data[31:0], 32'h33);
    i_alloc = 1'b1; i_alloc_addr = 5'd3;
    wr(0, 5'd3, 32'h34, 1'b1);
    tick(); idle();
    rd(5'd3, 5'd0);
    check("alloc_clr_busy", 32'(rd_busy[0]), 32'd1);
    check("alloc_clr_cnt", 32'(pend_cnt), 32'd1);

    // Build up pending bits, then flush with a competing alloc and a data write
    i_alloc = 1'b1; i_alloc_addr = 5'd1; tick();
    i_alloc_addr = 5'd2; tick();
    i_alloc_addr = 5'd4; tick();
    idle();
    check("pend_cnt_4", 32'(pend_cnt), 32'd4);
    i_flush = 1'b1; i_alloc = 1'b1; i_alloc_addr = 5'd6;
    wr(0, 5'd8, 32'h88, 1'b0);
    tick(); idle();
    check("flush_cnt", 32'(pend_cnt), 32'd0);
    rd(5'd1, 5'd6);
    check("flush_busy_x1", 32'(rd_busy[0]), 32'd0);
    check("flush_busy_x6", 32'(rd_busy[1]), 32'd0);
    rd(5'd3, 5'd8);
    check("flush_busy_x3", 32'(rd_busy[0]), 32'd0);
    check("flush_data_x8", rd_data[63:32], 32'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
